ifu_prefetch_queue: RTL and testbench

Parametrised instruction-fetch unit that replaces the single-request fetcher with a prefetching front end. It issues sequential AXI4 single-beat read requests, keeps up to MAX_OUTSTANDING in flight, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. The FIFO feeds the decode stage through a valid/ready handshake. A redirect from the execute stage flushes the FIFO and discards in-flight stale responses.

---
 rtl/ifu_prefetch_queue.sv | 144 ++++++++++++++
 tb/tb_ifu_prefetch_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifu_prefetch_queue : AXI4 sequential instruction prefetcher + PC FIFO     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module ifu_prefetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h3000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_inst_o,
  output logic        out_err_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  output logic [3:0]  arid_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic [3:0]  rid_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]      fetch_pc_q, araddr_q;
  logic             arvalid_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [OUT_W-1:0] n_out_q, n_out_d, n_drop_q, n_drop_d;
  logic [PQ_W-1:0]  pq_wr_q, pq_rd_q;
  logic [31:0]      pq_mem_q   [MAX_OUTSTANDING];
  logic [31:0]      pc_mem_q   [DEPTH];
  logic [31:0]      inst_mem_q [DEPTH];
  logic             err_mem_q  [DEPTH];

  logic        ar_hs, ar_pend, out_hs, r_push, issue;
  logic [31:0] next_base;
  logic        unused_axi;

  function automatic logic [PQ_W-1:0] pq_next(input logic [PQ_W-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PQ_W'(1);
  endfunction

  always_comb begin
    ar_hs   = arvalid_q & arready_i;
    ar_pend = arvalid_q & ~arready_i;
    out_hs  = out_valid_o & out_ready_i;
    // A beat in the redirect cycle is stale by definition; n_drop_d absorbs it.
    r_push  = rvalid_i & ~redirect_valid_i & (n_drop_q == '0);
    n_out_d = n_out_q + OUT_W'(ar_hs) - OUT_W'(rvalid_i);
    if (redirect_valid_i)
      n_drop_d = n_out_d + OUT_W'(ar_pend);
    else if (rvalid_i && (n_drop_q != '0))
      n_drop_d = n_drop_q - OUT_W'(1);
    else
      n_drop_d = n_drop_q;
    count_d   = redirect_valid_i ? '0 : (count_q + CNT_W'(r_push) - CNT_W'(out_hs));
    next_base = redirect_valid_i ? redirect_pc_i : fetch_pc_q;
    // Budget on post-update counters so every live response has a FIFO slot.
    issue = (!arvalid_q || ar_hs)
          && (int'(n_out_d) < MAX_OUTSTANDING)
          && ((int'(count_d) + int'(n_out_d) - int'(n_drop_d)) < DEPTH);
  end

  assign out_valid_o = (count_q != '0);
  assign out_pc_o    = pc_mem_q[rd_ptr_q];
  assign out_inst_o  = inst_mem_q[rd_ptr_q];
  assign out_err_o   = err_mem_q[rd_ptr_q];
  assign arvalid_o   = arvalid_q;
  assign araddr_o    = araddr_q;
  assign arid_o      = 4'd0;
  assign arlen_o     = 8'd0;
  assign arsize_o    = 3'b010;
  assign arburst_o   = 2'b01;
  assign rready_o    = 1'b1;
  assign unused_axi  = ^{rlast_i, rid_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      n_out_q    <= '0;
      n_drop_q   <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) pq_mem_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
        err_mem_q[i]  <= 1'b0;
      end
    end else begin
      count_q  <= count_d;
      n_out_q  <= n_out_d;
      n_drop_q <= n_drop_d;
      if (issue) begin
        arvalid_q  <= 1'b1;
        araddr_q   <= next_base;
        fetch_pc_q <= next_base + 32'd4;
      end else begin
        if (ar_hs) arvalid_q <= 1'b0;
        if (redirect_valid_i) fetch_pc_q <= redirect_pc_i;
      end
      if (ar_hs) begin
        pq_mem_q[pq_wr_q] <= araddr_q;
        pq_wr_q           <= pq_next(pq_wr_q);
      end
      if (rvalid_i) pq_rd_q <= pq_next(pq_rd_q);
      if (redirect_valid_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (r_push) begin
          pc_mem_q[wr_ptr_q]   <= pq_mem_q[pq_rd_q];
          inst_mem_q[wr_ptr_q] <= rdata_i;
          err_mem_q[wr_ptr_q]  <= (rresp_i != 2'b00);
          wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
        end
        if (out_hs) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch_queue.sv
`default_nettype none
// Directed bench for ifu_prefetch_queue: AXI slave + transaction-level model
// (request/response queues with redirect epochs) compared every cycle.
module tb_ifu_prefetch_queue;
  localparam logic [31:0] RESET_PC = 32'h3000_0000;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst_n, redirect, out_ready, arready, rvalid, rlast;
  logic [31:0] redirect_pc, rdata;
  logic [1:0] rresp;
  logic [3:0] rid;
  logic out_valid, out_err, arvalid, rready;
  logic [31:0] out_pc, out_inst, araddr;
  logic [3:0] arid;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;

  always #5 clk = ~clk;

  ifu_prefetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_valid_i(redirect), .redirect_pc_i(redirect_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc), .out_inst_o(out_inst),
    .out_err_o(out_err), .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr),
    .arid_o(arid), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata), .rresp_i(rresp),
    .rlast_i(rlast), .rid_i(rid));

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } ent_t;
  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;

  int checks = 0, failures = 0, cyc = 0, lat = 2, base = 0, n = 0;
  logic [31:0] err_addr = 32'h0000_0001;
  ent_t mq[$];
  req_t infl[$];
  logic [31:0] plog[$];
  logic elog[$];
  int epoch = 0, req_epoch = 0;
  bit in_req = 0;
  logic [31:0] next_pc = RESET_PC, req_addr = '0;
  logic s_rst_n, s_arvalid, s_arready, s_rvalid, s_out_valid, s_out_ready, s_redir;
  logic [31:0] s_redir_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Advance the model across one clock edge using values sampled just before it.
  task automatic model_update();
    req_t r;
    if (!s_rst_n) begin
      mq.delete(); infl.delete();
      epoch++; in_req = 0; next_pc = RESET_PC;
      return;
    end
    if (s_out_valid && s_out_ready && !s_redir && mq.size() > 0) begin
      plog.push_back(mq[0].pc);
      elog.push_back(mq[0].err);
      void'(mq.pop_front());
    end
    if (s_rvalid && infl.size() > 0) begin
      r = infl.pop_front();
      if (r.epoch == epoch && !s_redir)
        mq.push_back('{r.addr, inst_of(r.addr), r.addr == err_addr});
    end
    if (s_arvalid && s_arready) begin
      infl.push_back('{req_addr, req_epoch, cyc + lat});
      in_req = 0;
    end
    if (s_redir) begin
      mq.delete();
      epoch++;
      next_pc = s_redir_pc;
    end
  endtask

  task automatic monitor();
    if (!rst_n) begin
      rvalid = 1'b0;
      return;
    end
    chk("out_valid", out_valid, mq.size() != 0);
    if (out_valid && mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
      chk("out_err", out_err, mq[0].err);
    end
    if (arvalid) begin
      if (!in_req) begin
        chk("araddr_new", araddr, next_pc);
        in_req = 1; req_addr = araddr; req_epoch = epoch; next_pc = next_pc + 32'd4;
      end else begin
        chk("araddr_hold", araddr, req_addr);
      end
    end
    chk("outstanding_limit", 32'(infl.size() <= MAX_OUT), 32'd1);
    if (infl.size() > 0 && infl[0].due <= cyc + 1) begin
      rvalid = 1'b1;
      rdata = inst_of(infl[0].addr);
      rresp = (infl[0].addr == err_addr) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    end
  endtask

  // Must be entered on a falling clock edge; returns on the next falling edge.
  task automatic cycle();
    #4;
    s_rst_n = rst_n; s_arvalid = arvalid; s_arready = arready; s_rvalid = rvalid;
    s_out_valid = out_valid; s_out_ready = out_ready; s_redir = redirect; s_redir_pc = redirect_pc;
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
    monitor();
  endtask

  task automatic hold_reset();
    rst_n = 1'b0; redirect = 1'b0;
    cycle(); cycle();
  endtask

  task automatic run_plog(input int target, input int limit, input string name);
    int k = 0;
    while (plog.size() < target && k < limit) begin cycle(); k++; end
    if (plog.size() < target) timeout(name);
  endtask

  task automatic run_infl(input int target, input int limit, input string name);
    int k = 0;
    while (infl.size() != target && k < limit) begin cycle(); k++; end
    if (infl.size() != target) timeout(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_pc"}, out_pc, 0);
    chk({tag, "_out_inst"}, out_inst, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_rready"}, rready, 1);
  endtask

  initial begin
    rst_n = 1'b1; redirect = 1'b0; redirect_pc = '0; arready = 1'b0; out_ready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rid = 4'd0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    chk("arid", arid, 0);
    chk("arlen", arlen, 0);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);
    @(negedge clk);
    hold_reset();

    // Sequential stream, then steady-state throughput
    arready = 1'b1; out_ready = 1'b1; lat = 2; rst_n = 1'b1;
    cycle();
    chk("first_arvalid", arvalid, 1);
    chk("first_araddr", araddr, RESET_PC);
    base = plog.size();
    run_plog(base + 6, 60, "stream_wait");
    for (int i = 0; i < 6; i++)
      if (plog.size() > base + i) chk("stream_pc", plog[base + i], RESET_PC + 32'(4 * i));
    lat = 1;
    repeat (10) cycle();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (out_valid && out_ready) n++;
    end
    chk("throughput", n, 8);

    // FIFO full with decode stalled
    hold_reset();
    lat = 2; out_ready = 1'b0; rst_n = 1'b1;
    repeat (20) cycle();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (arvalid) n++;
    end
    chk("full_no_issue", n, 0);
    chk("full_head_pc", out_pc, RESET_PC);
    base = plog.size();
    out_ready = 1'b1;
    run_plog(base + 5, 60, "drain_wait");
    for (int i = 0; i < 5; i++)
      if (plog.size() > base + i) chk("drain_pc", plog[base + i], RESET_PC + 32'(4 * i));

    // Redirect with two requests in flight
    hold_reset();
    lat = 3; rst_n = 1'b1;
    run_infl(2, 30, "two_outstanding_wait");
    redirect = 1'b1; redirect_pc = 32'h8000_0000;
    cycle();
    redirect = 1'b0;
    chk("redirect_flush_valid", out_valid, 0);
    base = plog.size();
    run_plog(base + 2, 60, "redirect_wait");
    if (plog.size() > base + 1) begin
      chk("redirect_first_pc", plog[base], 32'h8000_0000);
      chk("redirect_second_pc", plog[base + 1], 32'h8000_0004);
    end

    // Redirect while an AR is stalled by arready=0
    hold_reset();
    lat = 2; arready = 1'b0; rst_n = 1'b1;
    cycle();
    redirect = 1'b1; redirect_pc = 32'h8000_0000;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stale_ar_valid", arvalid, 1);
      chk("stale_ar_addr", araddr, RESET_PC);
      cycle();
    end
    arready = 1'b1;
    cycle();
    chk("post_stale_arvalid", arvalid, 1);
    chk("post_stale_araddr", araddr, 32'h8000_0000);
    base = plog.size();
    run_plog(base + 1, 40, "post_stale_wait");
    if (plog.size() > base) chk("post_stale_first_pc", plog[base], 32'h8000_0000);

    // Error response on the second beat
    hold_reset();
    err_addr = RESET_PC + 32'd4; lat = 2; rst_n = 1'b1;
    base = plog.size();
    run_plog(base + 3, 40, "err_wait");
    if (plog.size() > base + 2) begin
      chk("err_pc1", plog[base + 1], RESET_PC + 32'd4);
      chk("err_flag0", elog[base], 0);
      chk("err_flag1", elog[base + 1], 1);
      chk("err_flag2", elog[base + 2], 0);
    end
    err_addr = 32'h0000_0001;

    // Asynchronous reset mid-burst
    lat = 3;
    run_infl(2, 30, "reset_burst_wait");
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    chk("restart_arvalid", arvalid, 1);
    chk("restart_araddr", araddr, RESET_PC);
    base = plog.size();
    run_plog(base + 2, 40, "restart_wait");
    if (plog.size() > base + 1) begin
      chk("restart_pc0", plog[base], RESET_PC);
      chk("restart_pc1", plog[base + 1], RESET_PC + 32'd4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
